// File: rtl/phase_timer_if.sv
// Control and timing-pulse bundle of phase_timer.
// The timer drives it through master; consumers use slave.
interface phase_timer_if #(
    parameter int NPHASE = 4,
    parameter int NTP    = 12,
    parameter int CW     = 8
);
    logic              STOP;
    logic              STEP;
    logic [NPHASE-1:0] PHS;
    logic [NPHASE-1:0] PHS_n;
    logic [NTP-1:0]    TP;
    logic              RT;
    logic              WT;
    logic              WT_n;
    logic              CT;
    logic              CT_n;
    logic              OVFSTB_n;
    logic              ODDSET;
    logic              EVNSET;
    logic [CW-1:0]     MCTCNT;
    logic              RUNNING;

    modport master (
        input  STOP, STEP,
        output PHS, PHS_n, TP, RT, WT, WT_n, CT, CT_n,
        output OVFSTB_n, ODDSET, EVNSET, MCTCNT, RUNNING
    );

    modport slave (
        output STOP, STEP,
        input  PHS, PHS_n, TP, RT, WT, WT_n, CT, CT_n,
        input  OVFSTB_n, ODDSET, EVNSET, MCTCNT, RUNNING
    );
endinterface

// File: rtl/phase_timer.sv
// Parametrised phase/timepulse generator with memory-cycle-aligned
// halt, single-cycle step and a completed-memory-cycle counter.
module phase_timer #(
    parameter int DIV    = 2,
    parameter int NPHASE = 4,
    parameter int NTP    = 12,
    parameter int RT_PH  = 0,
    parameter int WT_PH  = 1,
    parameter int CT_PH  = 2,
    parameter int OVF_TP = 1,
    parameter int CW     = 8
) (
    input  logic         CLOCK,
    input  logic         SIM_RST,
    phase_timer_if.master tim
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW = $clog2(NPHASE);
    localparam int TW = $clog2(NTP);

    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [HW-1:0] PH_MAX  = HW'(NPHASE - 1);
    localparam logic [TW-1:0] TP_MAX  = TW'(NTP - 1);
    localparam logic [HW-1:0] RT_IDX  = HW'(RT_PH);
    localparam logic [HW-1:0] WT_IDX  = HW'(WT_PH);
    localparam logic [HW-1:0] CT_IDX  = HW'(CT_PH);
    localparam logic [TW-1:0] OVF_IDX = TW'(OVF_TP);

    typedef enum logic [1:0] {
        S_RUN,
        S_HALT,
        S_STEP
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [HW-1:0] ph_q, ph_d;
    logic [TW-1:0] tp_q, tp_d;
    logic          odd_q, odd_d;
    logic [CW-1:0] mct_q, mct_d;
    logic          step_q;

    logic active;
    logic pre_wrap;
    logic ph_wrap;
    logic tp_wrap;
    logic eoc;
    logic step_rise;

    assign active    = (state_q != S_HALT);
    assign pre_wrap  = (pre_q == PRE_MAX);
    assign ph_wrap   = (ph_q == PH_MAX);
    assign tp_wrap   = (tp_q == TP_MAX);
    assign eoc       = active & pre_wrap & ph_wrap & tp_wrap;
    assign step_rise = tim.STEP & ~step_q;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        ph_d    = ph_q;
        tp_d    = tp_q;
        odd_d   = odd_q;
        mct_d   = mct_q;

        // STOP is only honoured at the memory-cycle boundary
        unique case (state_q)
            S_RUN, S_STEP: begin
                if (eoc) state_d = tim.STOP ? S_HALT : S_RUN;
            end
            S_HALT: begin
                if (!tim.STOP)     state_d = S_RUN;
                else if (step_rise) state_d = S_STEP;
            end
            default: state_d = S_RUN;
        endcase

        if (active) begin
            pre_d = pre_wrap ? '0 : pre_q + PW'(1);
            if (pre_wrap) begin
                ph_d = ph_wrap ? '0 : ph_q + HW'(1);
                if (ph_wrap) tp_d = tp_wrap ? '0 : tp_q + TW'(1);
            end
            if (eoc) begin
                odd_d = ~odd_q;
                mct_d = mct_q + CW'(1);
            end
        end else begin
            pre_d = '0;
            ph_d  = '0;
            tp_d  = '0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            state_q <= S_RUN;
            pre_q   <= '0;
            ph_q    <= '0;
            tp_q    <= '0;
            odd_q   <= 1'b1;
            mct_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ph_q    <= ph_d;
            tp_q    <= tp_d;
            odd_q   <= odd_d;
            mct_q   <= mct_d;
            step_q  <= tim.STEP;
        end
    end

    logic [NPHASE-1:0] phs;
    logic [NTP-1:0]    tpv;

    always_comb begin
        phs = '0;
        tpv = '0;
        for (int i = 0; i < NPHASE; i++) phs[i] = active & (ph_q == HW'(i));
        for (int j = 0; j < NTP; j++)    tpv[j] = active & (tp_q == TW'(j));
    end

    assign tim.PHS      = phs;
    assign tim.PHS_n    = ~phs;
    assign tim.TP       = tpv;
    assign tim.RT       = active & (ph_q == RT_IDX);
    assign tim.WT       = active & (ph_q == WT_IDX);
    assign tim.WT_n     = ~tim.WT;
    assign tim.CT       = active & (ph_q == CT_IDX);
    assign tim.CT_n     = ~tim.CT;
    assign tim.OVFSTB_n = ~(active & (tp_q == OVF_IDX) &
                            (ph_q == CT_IDX) & (pre_q == '0));
    assign tim.ODDSET   = odd_q;
    assign tim.EVNSET   = ~odd_q;
    assign tim.MCTCNT   = mct_q;
    assign tim.RUNNING  = active;
endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: default instance plus a
// DIV=1/NPHASE=3/NTP=2/CW=2 instance.
module tb_phase_timer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA, rstB;

    phase_timer_if #(.NPHASE(4), .NTP(12), .CW(8)) ia ();
    phase_timer_if #(.NPHASE(3), .NTP(2),  .CW(2)) ib ();

    phase_timer dutA (.CLOCK(clk), .SIM_RST(rstA), .tim(ia));
    phase_timer #(.DIV(1), .NPHASE(3), .NTP(2), .CW(2))
        dutB (.CLOCK(clk), .SIM_RST(rstB), .tim(ib));

    typedef struct packed {
        logic [3:0]  phs;
        logic [11:0] tp;
        logic        rt, wt, ct, ovf_n, odd, run, cmp;
        logic [7:0]  mct;
    } obs_t;

    typedef struct {
        string name;
        bit    b;
        obs_t  v;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Expected outputs of the default timer at position k of a memory cycle
    function automatic obs_t expA(int k, bit odd, int mct, bit run);
        obs_t e;
        int   ph, t;
        e       = '0;
        e.odd   = odd;
        e.mct   = 8'(mct);
        e.run   = run;
        e.cmp   = 1'b1;
        e.ovf_n = 1'b1;
        if (run) begin
            ph      = (k / 2) % 4;
            t       = k / 8;
            e.phs   = 4'(1 << ph);
            e.tp    = 12'(1 << t);
            e.rt    = (ph == 0);
            e.wt    = (ph == 1);
            e.ct    = (ph == 2);
            e.ovf_n = (k != 12);
        end
        return e;
    endfunction

    function automatic obs_t expB(int k, int cyc);
        obs_t e;
        int   ph, t;
        ph      = k % 3;
        t       = k / 3;
        e       = '0;
        e.odd   = (cyc % 2 == 0);
        e.mct   = 8'(cyc % 4);
        e.run   = 1'b1;
        e.cmp   = 1'b1;
        e.phs   = 4'(1 << ph);
        e.tp    = 12'(1 << t);
        e.rt    = (ph == 0);
        e.wt    = (ph == 1);
        e.ct    = (ph == 2);
        e.ovf_n = (k != 5);
        return e;
    endfunction

    function automatic obs_t actA();
        obs_t a;
        a.phs   = ia.PHS;
        a.tp    = ia.TP;
        a.rt    = ia.RT;
        a.wt    = ia.WT;
        a.ct    = ia.CT;
        a.ovf_n = ia.OVFSTB_n;
        a.odd   = ia.ODDSET;
        a.run   = ia.RUNNING;
        a.mct   = ia.MCTCNT;
        a.cmp   = (ia.PHS_n === ~ia.PHS) && (ia.WT_n === ~ia.WT) &&
                  (ia.CT_n === ~ia.CT) && (ia.EVNSET === ~ia.ODDSET);
        return a;
    endfunction

    function automatic obs_t actB();
        obs_t a;
        a.phs   = {1'b0, ib.PHS};
        a.tp    = {10'b0, ib.TP};
        a.rt    = ib.RT;
        a.wt    = ib.WT;
        a.ct    = ib.CT;
        a.ovf_n = ib.OVFSTB_n;
        a.odd   = ib.ODDSET;
        a.run   = ib.RUNNING;
        a.mct   = {6'b0, ib.MCTCNT};
        a.cmp   = (ib.PHS_n === ~ib.PHS) && (ib.WT_n === ~ib.WT) &&
                  (ib.CT_n === ~ib.CT) && (ib.EVNSET === ~ib.ODDSET);
        return a;
    endfunction

    exp_t me;
    obs_t ma;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            me = q.pop_front();
            ma = me.b ? actB() : actA();
            checks++;
            if (ma !== me.v) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", me.name, ma, me.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pA(string n, int k, bit odd, int mct, bit run);
        exp_t t;
        t.name = $sformatf("%s k%0d", n, k);
        t.b    = 1'b0;
        t.v    = expA(k, odd, mct, run);
        q.push_back(t);
    endtask

    task automatic pB(string n, int k, int cyc);
        exp_t t;
        t.name = $sformatf("%s k%0d c%0d", n, k, cyc);
        t.b    = 1'b1;
        t.v    = expB(k, cyc);
        q.push_back(t);
    endtask

    initial begin
        rstA    = 1'b1;
        rstB    = 1'b1;
        ia.STOP = 1'b0;
        ia.STEP = 1'b0;
        ib.STOP = 1'b0;
        ib.STEP = 1'b0;
        tick();
        rstA = 1'b0;
        rstB = 1'b0;

        // small config: 6-clock memory cycle, MCTCNT wraps 3->0
        for (int c = 0; c < 30; c++) begin
            pB("small", c % 6, c / 6);
            tick();
        end

        // free run from reset
        rstA = 1'b1;
        tick();
        rstA = 1'b0;
        for (int c = 0; c <= 200; c++) begin
            pA("run", c % 96, (c / 96) % 2 == 0, c / 96, 1'b1);
            tick();
        end

        // STOP mid-cycle halts only at the boundary
        rstA = 1'b1;
        tick();
        rstA = 1'b0;
        for (int c = 0; c < 106; c++) begin
            if (c < 96) pA("stop", c, 1'b1, 0, 1'b1);
            else        pA("halt", 0, 1'b0, 1, 1'b0);
            if (c == 40) ia.STOP = 1'b1;
            tick();
        end

        // 3-clock STEP pulse, second pulse during the step ignored
        ia.STEP = 1'b1;
        pA("halt", 0, 1'b0, 1, 1'b0);
        tick();
        for (int k = 0; k < 96; k++) begin
            if (k == 2)  ia.STEP = 1'b0;
            if (k == 30) ia.STEP = 1'b1;
            if (k == 31) ia.STEP = 1'b0;
            pA("step", k, 1'b0, 1, 1'b1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            pA("stephalt", 0, 1'b1, 2, 1'b0);
            tick();
        end

        // drop STOP during a step: continue straight into RUN
        ia.STEP = 1'b1;
        pA("halt2", 0, 1'b1, 2, 1'b0);
        tick();
        ia.STEP = 1'b0;
        for (int k = 0; k < 96; k++) begin
            if (k == 50) ia.STOP = 1'b0;
            pA("step2", k, 1'b1, 2, 1'b1);
            tick();
        end
        for (int k = 0; k <= 40; k++) begin
            pA("cont", k, 1'b0, 3, 1'b1);
            if (k == 40) rstA = 1'b1;
            tick();
        end

        // reset mid-RUN at tp=5
        rstA = 1'b0;
        pA("rstrun0", 0, 1'b1, 0, 1'b1);
        tick();
        pA("rstrun1", 1, 1'b1, 0, 1'b1);
        ia.STOP = 1'b1;
        tick();
        for (int c = 2; c < 101; c++) begin
            if (c < 96) pA("stop2", c, 1'b1, 0, 1'b1);
            else        pA("halt3", 0, 1'b0, 1, 1'b0);
            tick();
        end

        // reset mid-HALT
        pA("halt4", 0, 1'b0, 1, 1'b0);
        rstA = 1'b1;
        tick();
        rstA = 1'b0;
        pA("rsthalt0", 0, 1'b1, 0, 1'b1);
        tick();
        pA("rsthalt1", 1, 1'b1, 0, 1'b1);
        ia.STOP = 1'b0;
        tick();

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
